// File: rtl/bufm_id_alloc.sv
// bufm_id_alloc: buffer-ID pool with rotating-priority grant, dual-port reclaim, flush and idle-count publishing.
// Grant search and free legality both look at the map as it stood at the start of the cycle.
module bufm_id_alloc #(
    parameter int ID_NUM = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_alloc_req,
    output logic [4:0]  out_alloc_id,
    output logic        out_alloc_id_wr,
    output logic        out_alloc_fail,
    input  logic [4:0]  in_free_id_a,
    input  logic        in_free_id_a_wr,
    input  logic [4:0]  in_free_id_b,
    input  logic        in_free_id_b_wr,
    input  logic        in_flush,
    output logic        out_free_err,
    output logic [4:0]  bufm_ID_count,
    output logic [15:0] alloc_fail_cnt,
    output logic [15:0] free_err_cnt
);
    localparam logic [5:0] NUM6 = 6'(ID_NUM);
    localparam logic [4:0] NUM5 = 5'(ID_NUM);

    logic [ID_NUM-1:0] r_idle_map;
    logic [4:0]        r_rr_ptr;
    logic [4:0]        r_count;
    logic [15:0]       r_afc;
    logic [15:0]       r_fec;
    logic [4:0]        r_id;
    logic              r_id_wr;
    logic              r_fail;
    logic              r_err;

    logic [31:0]       w_map;
    logic [5:0]        w_idx;
    logic              w_found;
    logic [4:0]        w_gnt_id;
    logic              w_gnt;
    logic              w_fail;
    logic              w_la;
    logic              w_lb;
    logic              w_ea;
    logic              w_eb;
    logic [ID_NUM-1:0] w_nxt_map;
    logic [4:0]        w_nxt_rr;
    logic [4:0]        w_nxt_cnt;
    logic [16:0]       w_afc_sum;
    logic [16:0]       w_fec_sum;

    assign w_map = 32'(r_idle_map);

    // Scan offsets high to low so the idle ID nearest rr_ptr is the one kept.
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        w_idx    = '0;
        for (int i = ID_NUM - 1; i >= 0; i--) begin
            w_idx = {1'b0, r_rr_ptr} + 6'(i);
            if (w_idx >= NUM6) w_idx = w_idx - NUM6;
            if (w_map[w_idx[4:0]]) begin
                w_found  = 1'b1;
                w_gnt_id = w_idx[4:0];
            end
        end
    end

    assign w_la   = !in_flush && in_free_id_a_wr && ({1'b0, in_free_id_a} < NUM6) && !w_map[in_free_id_a];
    assign w_lb   = !in_flush && in_free_id_b_wr && ({1'b0, in_free_id_b} < NUM6) && !w_map[in_free_id_b]
                    && !(w_la && in_free_id_a == in_free_id_b);
    assign w_ea   = !in_flush && in_free_id_a_wr && !w_la;
    assign w_eb   = !in_flush && in_free_id_b_wr && !w_lb;
    assign w_gnt  = in_alloc_req && !in_flush && w_found;
    assign w_fail = in_alloc_req && !w_gnt;

    always_comb begin
        w_nxt_map = r_idle_map;
        for (int k = 0; k < ID_NUM; k++) begin
            if (w_gnt && w_gnt_id == 5'(k)) w_nxt_map[k] = 1'b0;
            if ((w_la && in_free_id_a == 5'(k)) || (w_lb && in_free_id_b == 5'(k))) w_nxt_map[k] = 1'b1;
        end
    end

    assign w_nxt_rr  = ({1'b0, w_gnt_id} + 6'd1 == NUM6) ? 5'd0 : w_gnt_id + 5'd1;
    assign w_nxt_cnt = r_count - 5'(w_gnt) + 5'(w_la) + 5'(w_lb);
    assign w_afc_sum = {1'b0, r_afc} + 17'(w_fail);
    assign w_fec_sum = {1'b0, r_fec} + 17'(w_ea) + 17'(w_eb);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle_map <= '1;
            r_rr_ptr   <= '0;
            r_count    <= NUM5;
            r_afc      <= '0;
            r_fec      <= '0;
            r_id       <= '0;
            r_id_wr    <= 1'b0;
            r_fail     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_id_wr <= w_gnt;
            r_fail  <= w_fail;
            r_err   <= w_ea | w_eb;
            if (w_gnt) r_id <= w_gnt_id;
            r_afc   <= w_afc_sum[16] ? 16'hFFFF : w_afc_sum[15:0];
            r_fec   <= w_fec_sum[16] ? 16'hFFFF : w_fec_sum[15:0];
            if (in_flush) begin
                r_idle_map <= '1;
                r_count    <= NUM5;
                r_rr_ptr   <= '0;
            end else begin
                r_idle_map <= w_nxt_map;
                r_count    <= w_nxt_cnt;
                if (w_gnt) r_rr_ptr <= w_nxt_rr;
            end
        end
    end

    assign out_alloc_id    = r_id;
    assign out_alloc_id_wr = r_id_wr;
    assign out_alloc_fail  = r_fail;
    assign out_free_err    = r_err;
    assign bufm_ID_count   = r_count;
    assign alloc_fail_cnt  = r_afc;
    assign free_err_cnt    = r_fec;
endmodule

// File: tb/tb_bufm_id_alloc.sv
// tb_bufm_id_alloc: randomized + directed bench; an ID-pool model predicts each cycle's response into a scoreboard queue.
module tb_bufm_id_alloc;
    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        fa_wr = 1'b0;
    logic        fb_wr = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  fa = '0;
    logic [4:0]  fb = '0;
    logic [4:0]  out_alloc_id;
    logic        out_alloc_id_wr;
    logic        out_alloc_fail;
    logic        out_free_err;
    logic [4:0]  bufm_ID_count;
    logic [15:0] alloc_fail_cnt;
    logic [15:0] free_err_cnt;

    bufm_id_alloc #(.ID_NUM(N)) dut (
        .clk(clk), .rst(rst), .in_alloc_req(req),
        .out_alloc_id(out_alloc_id), .out_alloc_id_wr(out_alloc_id_wr), .out_alloc_fail(out_alloc_fail),
        .in_free_id_a(fa), .in_free_id_a_wr(fa_wr), .in_free_id_b(fb), .in_free_id_b_wr(fb_wr),
        .in_flush(flush), .out_free_err(out_free_err), .bufm_ID_count(bufm_ID_count),
        .alloc_fail_cnt(alloc_fail_cnt), .free_err_cnt(free_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit gnt;
        bit fail;
        int id;
        bit err;
        int cnt;
        int afc;
        int fec;
    } exp_t;

    exp_t q[$];
    bit   m_idle[N];
    int   m_rr, m_afc, m_fec;
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic void m_reset();
        for (int i = 0; i < N; i++) m_idle[i] = 1'b1;
        m_rr  = 0;
        m_afc = 0;
        m_fec = 0;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_idle[i]);
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_chk++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One stimulus cycle; the pool model predicts what the DUT shows after the next rising edge.
    task automatic cyc(input bit r, input bit aw, input int a, input bit bw, input int b, input bit fl);
        exp_t e;
        int   g;
        bit   la, lb;
        @(negedge clk);
        req = r; fa_wr = aw; fa = 5'(a); fb_wr = bw; fb = 5'(b); flush = fl;
        e = '{default: 0};
        if (fl) begin
            e.fail = r;
            if (r) m_afc++;
            for (int i = 0; i < N; i++) m_idle[i] = 1'b1;
            m_rr = 0;
        end else begin
            g = -1;
            if (r) for (int k = 0; k < N; k++) if (g < 0 && m_idle[(m_rr + k) % N]) g = (m_rr + k) % N;
            la = aw && a < N && !m_idle[a % N];
            lb = bw && b < N && !m_idle[b % N] && !(la && a == b);
            if (r && g >= 0) begin
                e.gnt = 1'b1;
                e.id = g;
                m_idle[g] = 1'b0;
                m_rr = (g + 1) % N;
            end else if (r) begin
                e.fail = 1'b1;
                m_afc++;
            end
            if (la) m_idle[a] = 1'b1;
            if (lb) m_idle[b] = 1'b1;
            e.err = (aw && !la) || (bw && !lb);
            m_fec += int'(aw && !la) + int'(bw && !lb);
        end
        if (m_afc > 65535) m_afc = 65535;
        if (m_fec > 65535) m_fec = 65535;
        e.cnt = m_count();
        e.afc = m_afc;
        e.fec = m_fec;
        q.push_back(e);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic reset_checks();
        check("rst_id", out_alloc_id, 0);
        check("rst_id_wr", out_alloc_id_wr, 0);
        check("rst_fail", out_alloc_fail, 0);
        check("rst_err", out_free_err, 0);
        check("rst_count", bufm_ID_count, N);
        check("rst_afc", alloc_fail_cnt, 0);
        check("rst_fec", free_err_cnt, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) continue;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("grant_wr", out_alloc_id_wr, int'(e.gnt));
                check("alloc_fail", out_alloc_fail, int'(e.fail));
                if (e.gnt) check("grant_id", out_alloc_id, e.id);
                check("free_err", out_free_err, int'(e.err));
                check("id_count", bufm_ID_count, e.cnt);
                check("alloc_fail_cnt", alloc_fail_cnt, e.afc);
                check("free_err_cnt", free_err_cnt, e.fec);
            end else if (out_alloc_id_wr || out_alloc_fail || out_free_err) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_strobe: wr=%0b fail=%0b err=%0b with no outstanding stimulus",
                         out_alloc_id_wr, out_alloc_fail, out_free_err);
            end
        end
    end

    initial begin
        m_reset();
        repeat (3) @(negedge clk);
        #1 reset_checks();
        @(negedge clk);
        rst = 1'b0;
        // fill and exhaust
        repeat (17) cyc(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        // rotation
        cyc(1'b0, 1'b1, 9, 1'b0, 0, 1'b0);
        cyc(1'b0, 1'b1, 2, 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        cyc(1'b0, 1'b1, 2, 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        // free and request together at empty
        cyc(1'b1, 1'b1, 5, 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        // duplicate free, then repeat free of an idle ID
        cyc(1'b0, 1'b1, 3, 1'b1, 3, 1'b0);
        idle();
        cyc(1'b0, 1'b1, 3, 1'b0, 0, 1'b0);
        // out-of-range ID
        cyc(1'b0, 1'b1, 20, 1'b0, 0, 1'b0);
        // flush under load
        cyc(1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
        repeat (10) cyc(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b0, 0, 1'b1, 4, 1'b1);
        cyc(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        idle();
        // random traffic with one asynchronous reset midway
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) begin
                idle();
                @(negedge clk);
                rst = 1'b1;
                #1 reset_checks();
                m_reset();
                @(negedge clk);
                rst = 1'b0;
            end
            cyc($urandom_range(0, 99) < 60,
                $urandom_range(0, 99) < 35,
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, N - 1)),
                $urandom_range(0, 99) < 25,
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, N - 1)),
                $urandom_range(0, 299) == 0);
        end
        repeat (3) idle();
        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
        #2;
        if (q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d responses outstanding, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bufm_id_alloc.md
# bufm_id_alloc

Buffer-ID allocator for the buffer manager (bufm) in the TSN switching pipeline. It owns a pool of packet-buffer IDs and grants one ID per request to the ingress buffer writer. It reclaims IDs returned by the egress path after transmit and by the discard path. It publishes the live idle-ID count, `bufm_ID_count`, which the packet action/classification stage uses for threshold-based traffic regulation.

## Interface
Parameters:
- `ID_NUM`, default 16: number of buffer IDs in the pool. Legal range is 2..31; IDs are 0..ID_NUM-1.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_alloc_req`  in  1  single-cycle pulse requesting one ID. May be asserted every cycle.
- `out_alloc_id`  out  5  granted ID; meaningful only while `out_alloc_id_wr`=1.
- `out_alloc_id_wr`  out  1  grant strobe.
- `out_alloc_fail`  out  1  pulse: request could not be granted.
- `in_free_id_a` / `in_free_id_a_wr`  in  5 / 1  ID returned by egress after transmit.
- `in_free_id_b` / `in_free_id_b_wr`  in  5 / 1  ID returned by discard path.
- `in_flush`  in  1  single-cycle pulse: return the whole pool to idle.
- `out_free_err`  out  1  pulse: an illegal free was detected.
- `bufm_ID_count`  out  5  number of idle IDs.
- `alloc_fail_cnt`  out  16  saturating count of failed requests, for lcm.
- `free_err_cnt`  out  16  saturating count of illegal frees, for lcm.

## Operation
- State:
  - `idle_map[ID_NUM-1:0]`: 1 means the ID is idle.
  - `rr_ptr` (5 bits): the search start point.
  - `bufm_ID_count`.
  - The two statistics counters.
- Allocation:
  - On `in_alloc_req`, search `idle_map` as it stands at the start of the cycle (pre-update).
  - The search is a rotating-priority scan starting at `rr_ptr` and wrapping at ID_NUM-1→0.
  - The first idle ID g found is granted: clear bit g, and set `rr_ptr` = g+1, or 0 if g+1 == ID_NUM.
  - If no ID is idle (`bufm_ID_count`==0), pulse `out_alloc_fail` and increment `alloc_fail_cnt`.
- Free:
  - A free on either port is legal only if the ID < ID_NUM and its `idle_map` bit is 0 at the start of the cycle.
  - A legal free sets the bit.
  - An illegal free leaves the map unchanged, pulses `out_free_err`, and increments `free_err_cnt` by 1 per illegal free in that cycle (so by 2 if both are illegal).
- Both ports freeing the same legal ID in the same cycle:
  - Port a is accepted.
  - Port b counts as illegal.
- Freeing an ID in the same cycle as allocating:
  - The freed ID is not eligible for that cycle's grant, because the search uses the pre-update map.
- Count update: `bufm_ID_count` next = current − granted + legal frees. It never exceeds ID_NUM and never underflows.
- Flush:
  - `in_flush` has top priority.
  - `idle_map` becomes all ones, count = ID_NUM, `rr_ptr` = 0.
  - A same-cycle request is failed: fail pulse, and `alloc_fail_cnt` increments.
  - Same-cycle frees are ignored without error.
- Statistics counters saturate at 16'hFFFF and are cleared only by `rst`.

## Timing
- Reset values:
  - `out_alloc_id` = 0, `out_alloc_id_wr` = 0, `out_alloc_fail` = 0, `out_free_err` = 0.
  - `bufm_ID_count` = ID_NUM.
  - `alloc_fail_cnt` = 0, `free_err_cnt` = 0.
  - `idle_map` all ones, `rr_ptr` = 0.
- All outputs are registered. There is no ready/backpressure: every request is answered with exactly one of grant or fail.
- Request at cycle N:
  - `out_alloc_id_wr` or `out_alloc_fail` is high in cycle N+1, for exactly one cycle.
  - The map, `rr_ptr` and count reflect the grant from N+1.
- Free at cycle N:
  - The bit is visible to the allocation search at N+1.
  - `bufm_ID_count` and `out_free_err` are updated at N+1.
- Back-to-back requests on consecutive cycles receive distinct IDs with no bubbles until the pool is empty.
- Reset asserted mid-operation: all state returns to the reset values immediately (asynchronously). Outstanding IDs are considered reclaimed.

## Test plan
- **Fill and exhaust.** ID_NUM=16; after reset, 17 consecutive request pulses → grants 0,1,…,15 on cycles 1–16, `bufm_ID_count` steps 16→0, and the 17th request yields `out_alloc_fail`, with `alloc_fail_cnt`=1.
- **Rotation.** With all 16 allocated, free 9 then 2 (separate cycles); two requests → grants 2 then 9, because `rr_ptr` wrapped to 0. Then free 2, allocate once with `rr_ptr`=10 → grant 2.
- **Simultaneous free and request at empty.** Count=0; free a=5 and request in the same cycle → fail pulse, count=1. Next request → grant 5, count=0.
- **Duplicate free.** ID 3 allocated; a=3 and b=3 in the same cycle → count +1 only, one `out_free_err` pulse, `free_err_cnt`=1. Later a=3 again → error, `free_err_cnt`=2.
- **Illegal ID.** Free a=20 with ID_NUM=16 → `out_free_err`, map and count unchanged.
- **Flush under load.** Allocate 10; `in_flush` together with a request and free b=4 → next cycle count=16, fail pulse, no error. Next request → grant 0.
